// File: rtl/hash160_host_if.sv
// Host-side framer for a HASH160 core: sends preamble + 64-byte block, then collects a 5-word digest.
// Optional digest comparator enabled by defining HASH160_HOST_CMP_EN.
module hash160_host_if #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  PREAMBLE_BYTE  = 8'hFF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [511:0]   i_block,
    output logic [7:0]     o_text,
    input  logic           i_valid,
    input  logic [31:0]    i_answer,
    output logic           o_busy,
    output logic           o_done,
    output logic [159:0]   o_digest,
`ifdef HASH160_HOST_CMP_EN
    input  logic [159:0]   i_expected,
    output logic           o_match,
`endif
    output logic           o_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        SEND    = 3'd2,
        WAIT    = 3'd3,
        COLLECT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    state_t         state_q, state_d;
    logic [511:0]   shift_q, shift_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [15:0]    wait_q, wait_d;
    logic [2:0]     wc_q, wc_d;
    logic [159:0]   digest_q, digest_d;
    logic           err_q, err_d;
    logic [7:0]     text_q, text_d;
    logic [15:0]    wait_inc;

    assign wait_inc = wait_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PRE;
            PRE:     state_d = SEND;
            SEND:    if (cnt_q == 7'd64) state_d = WAIT;
            WAIT: begin
                if (i_valid)                     state_d = COLLECT;
                else if (wait_inc == TIMEOUT_W)  state_d = DONE;
            end
            COLLECT: if (!i_valid || wc_q == 3'd4) state_d = DONE;
            DONE:    if (start) state_d = PRE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: o_text is registered, so it is computed from the state being entered.
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        wc_d     = wc_q;
        digest_d = digest_q;
        err_d    = err_q;
        text_d   = 8'h00;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shift_d  = i_block;
                    cnt_d    = 7'd0;
                    wait_d   = 16'd0;
                    wc_d     = 3'd0;
                    digest_d = '0;
                    err_d    = 1'b0;
                    text_d   = PREAMBLE_BYTE;
                end
            end
            PRE: begin
                text_d  = shift_q[511:504];
                shift_d = {shift_q[503:0], 8'h00};
                cnt_d   = 7'd1;
            end
            SEND: begin
                if (cnt_q != 7'd64) begin
                    text_d  = shift_q[511:504];
                    shift_d = {shift_q[503:0], 8'h00};
                    cnt_d   = cnt_q + 7'd1;
                end
            end
            WAIT: begin
                wait_d = wait_inc;
                if (i_valid) begin
                    digest_d[159:128] = i_answer;
                    wc_d              = 3'd1;
                end else if (wait_inc == TIMEOUT_W) begin
                    err_d = 1'b1;
                end
            end
            COLLECT: begin
                if (i_valid) begin
                    case (wc_q)
                        3'd1:    digest_d[127:96] = i_answer;
                        3'd2:    digest_d[95:64]  = i_answer;
                        3'd3:    digest_d[63:32]  = i_answer;
                        default: digest_d[31:0]   = i_answer;
                    endcase
                    wc_d = wc_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            wc_q     <= '0;
            digest_q <= '0;
            err_q    <= 1'b0;
            text_q   <= 8'h00;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            wc_q     <= wc_d;
            digest_q <= digest_d;
            err_q    <= err_d;
            text_q   <= text_d;
        end
    end

    always_comb begin
        o_busy = (state_q != IDLE) && (state_q != DONE);
        o_done = (state_q == DONE);
`ifdef HASH160_HOST_CMP_EN
        o_match = (state_q == DONE) && !err_q && (digest_q == i_expected);
`endif
    end

    assign o_text   = text_q;
    assign o_digest = digest_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_hash160_host_if.sv
// Directed bench for hash160_host_if: framing, digest collection, timeout, short burst, async reset.
module tb_hash160_host_if;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [511:0] i_block;
    logic [7:0]   o_text;
    logic         i_valid;
    logic [31:0]  i_answer;
    logic         o_busy;
    logic         o_done;
    logic [159:0] o_digest;
    logic         o_err;
`ifdef HASH160_HOST_CMP_EN
    logic [159:0] i_expected;
    logic         o_match;
`endif

    int checks = 0;
    int errors = 0;

    hash160_host_if #(.TIMEOUT_CYCLES(8), .PREAMBLE_BYTE(8'hFF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .i_block(i_block),
        .o_text(o_text),
        .i_valid(i_valid),
        .i_answer(i_answer),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_digest(o_digest),
`ifdef HASH160_HOST_CMP_EN
        .i_expected(i_expected),
        .o_match(o_match),
`endif
        .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    localparam logic [159:0] DIG_OK  = 160'h1111111122222222333333334444444455555555;
    localparam logic [159:0] DIG_SHT = 160'hAAAAAAAABBBBBBBBCCCCCCCC0000000000000000;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        i_valid  = 1'b0;
        i_answer = 32'h0;
        for (int i = 0; i < 64; i++) i_block[511-8*i -: 8] = 8'(i + 1);
`ifdef HASH160_HOST_CMP_EN
        i_expected = '0;
`endif
        step();
        step();
        check("rst_text",   {152'h0, o_text},   160'h0);
        check("rst_busy",   {159'h0, o_busy},   160'h0);
        check("rst_done",   {159'h0, o_done},   160'h0);
        check("rst_digest", o_digest,           160'h0);
        check("rst_err",    {159'h0, o_err},    160'h0);
`ifdef HASH160_HOST_CMP_EN
        check("rst_match",  {159'h0, o_match},  160'h0);
`endif

        // Normal transaction; start on the first edge after reset release.
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("pre_text", {152'h0, o_text}, 160'hFF);
        check("pre_busy", {159'h0, o_busy}, 160'h1);
        i_valid  = 1'b1;
        i_answer = 32'hDEADBEEF;
        for (int i = 0; i < 64; i++) begin
            step();
            check($sformatf("send_byte%0d", i), {152'h0, o_text}, 160'(i + 1));
        end
        i_valid = 1'b0;
        step();
        check("wait_text", {152'h0, o_text}, 160'h0);
        check("wait_busy", {159'h0, o_busy}, 160'h1);
        check("wait_digest_clean", o_digest, 160'h0);
        i_valid = 1'b1;
        i_answer = 32'h11111111; step();
        i_answer = 32'h22222222; step();
        i_answer = 32'h33333333; step();
        i_answer = 32'h44444444; step();
        check("coll_done_pending", {159'h0, o_done}, 160'h0);
        i_answer = 32'h55555555; step();
        i_answer = 32'h99999999; step();
        i_valid = 1'b0;
        check("ok_done",   {159'h0, o_done}, 160'h1);
        check("ok_busy",   {159'h0, o_busy}, 160'h0);
        check("ok_err",    {159'h0, o_err},  160'h0);
        check("ok_digest", o_digest,         DIG_OK);
        check("ok_text",   {152'h0, o_text}, 160'h0);
`ifdef HASH160_HOST_CMP_EN
        i_expected = DIG_OK;
        #1;
        check("match_eq", {159'h0, o_match}, 160'h1);
        i_expected = DIG_OK ^ 160'h1;
        #1;
        check("match_flip", {159'h0, o_match}, 160'h0);
`endif

        // Timeout: back-to-back start from DONE, no answer.
        start = 1'b1;
        step();
        start = 1'b0;
        check("t_pre_text",   {152'h0, o_text}, 160'hFF);
        check("t_digest_clr", o_digest,         160'h0);
        for (int i = 0; i < 65; i++) step();
        check("t_wait_busy", {159'h0, o_busy}, 160'h1);
        for (int i = 0; i < 7; i++) step();
        check("t_done_early", {159'h0, o_done}, 160'h0);
        step();
        check("t_done",   {159'h0, o_done}, 160'h1);
        check("t_err",    {159'h0, o_err},  160'h1);
        check("t_digest", o_digest,         160'h0);

        // Short answer burst.
        start = 1'b1;
        step();
        start = 1'b0;
        check("s_err_clr", {159'h0, o_err}, 160'h0);
        for (int i = 0; i < 65; i++) step();
        i_valid = 1'b1;
        i_answer = 32'hAAAAAAAA; step();
        i_answer = 32'hBBBBBBBB; step();
        i_answer = 32'hCCCCCCCC; step();
        i_valid = 1'b0;
        check("s_busy_mid", {159'h0, o_busy}, 160'h1);
        step();
        check("s_done",   {159'h0, o_done}, 160'h1);
        check("s_err",    {159'h0, o_err},  160'h1);
        check("s_digest", o_digest,         DIG_SHT);
`ifdef HASH160_HOST_CMP_EN
        i_expected = DIG_SHT;
        #1;
        check("s_match_err", {159'h0, o_match}, 160'h0);
`endif

        // Asynchronous reset in the middle of SEND.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 31; i++) step();
        check("r_byte30", {152'h0, o_text}, 160'h1F);
        rst_n = 1'b0;
        #1;
        check("r_text", {152'h0, o_text}, 160'h0);
        check("r_busy", {159'h0, o_busy}, 160'h0);
        check("r_done", {159'h0, o_done}, 160'h0);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        i_block = {64{8'h77}};
        check("r_pre", {152'h0, o_text}, 160'hFF);
        step();
        check("r_byte0", {152'h0, o_text}, 160'h01);
        step();
        start = 1'b0;
        check("r_byte1", {152'h0, o_text}, 160'h02);
        step();
        check("r_byte2", {152'h0, o_text}, 160'h03);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
